// File: rtl/bf_round_engine.sv
// bf_round_engine: Blowfish 16-round sequencer driving P memory and S-box read channel.
// Optional BF_ENC_COUNT_EN adds the enc_count result counter.
module bf_round_engine #(
  parameter int MSB = 31,
  parameter int P_ADDR_NBITS = 5
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MSB:0]            L_in,
  input  logic [MSB:0]            R_in,
  output logic                    ready,
  output logic [P_ADDR_NBITS-1:0] p_addr,
  input  logic [MSB:0]            p_dout,
  output logic                    s_rd_en,
  output logic                    s_rst_rd,
  output logic [MSB:0]            s_addr_rd,
  input  logic [MSB:0]            s_out,
  output logic                    valid,
  input  logic                    ack,
  output logic [MSB:0]            L_out,
  output logic [MSB:0]            R_out
`ifdef BF_ENC_COUNT_EN
  ,output logic [31:0]            enc_count
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, RD, F, FINAL, DONE} state_t;
  state_t state;
  logic [MSB:0] l, r;
  logic [3:0] round;
  assign s_rd_en = state == RD;
  assign s_rst_rd = state == IDLE;
  assign s_addr_rd = s_rd_en ? l : '0;
  always_ff @(posedge CLK)
    if (rst) begin
      state <= IDLE;
      ready <= 1'b0;
      valid <= 1'b0;
      L_out <= '0;
      R_out <= '0;
      p_addr <= '0;
      round <= '0;
      l <= '0;
      r <= '0;
    end else
      case (state)
        IDLE: begin
          ready <= 1'b1;
          p_addr <= '0;
          if (start && ready) begin
            l <= L_in;
            r <= R_in;
            round <= '0;
            ready <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          l <= l ^ p_dout;
          p_addr <= P_ADDR_NBITS'(1);
          state <= RD;
        end
        RD: state <= F;
        F: begin
          l <= r ^ s_out ^ p_dout;
          r <= l;
          round <= round + 4'(round != 4'd15);
          p_addr <= P_ADDR_NBITS'(round) + P_ADDR_NBITS'(2);
          state <= round == 4'd15 ? FINAL : RD;
        end
        FINAL: begin
          L_out <= r ^ p_dout;
          R_out <= l;
          valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (ack) begin
          valid <= 1'b0;
          ready <= 1'b1;
          p_addr <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef BF_ENC_COUNT_EN
  always_ff @(posedge CLK)
    if (rst) enc_count <= '0;
    else if (state == DONE && ack) enc_count <= enc_count + 32'd1;
`endif
endmodule

// File: tb/tb_bf_round_engine.sv
// tb_bf_round_engine: vector table plus randomized P/S runs against a software Blowfish-style model.
module tb_bf_round_engine;
  logic CLK = 0, rst = 1, start = 0, ack = 0;
  logic [31:0] L_in = 0, R_in = 0;
  logic ready, s_rd_en, s_rst_rd, valid;
  logic [4:0] p_addr;
  logic [31:0] p_dout, s_addr_rd, s_out, L_out, R_out;
`ifdef BF_ENC_COUNT_EN
  logic [31:0] enc_count;
`endif
  bf_round_engine dut (
    .CLK(CLK), .rst(rst), .start(start), .L_in(L_in), .R_in(R_in), .ready(ready),
    .p_addr(p_addr), .p_dout(p_dout), .s_rd_en(s_rd_en), .s_rst_rd(s_rst_rd),
    .s_addr_rd(s_addr_rd), .s_out(s_out), .valid(valid), .ack(ack),
    .L_out(L_out), .R_out(R_out)
`ifdef BF_ENC_COUNT_EN
    , .enc_count(enc_count)
`endif
  );
  always #5 CLK = ~CLK;
  logic [31:0] P [18];
  logic [31:0] S [4][256];
  logic [31:0] exp_addr [16];
  int n_chk = 0, n_fail = 0;
  int unsigned cyc = 0;
  int unsigned valid_cyc = 0;
  assign p_dout = (p_addr < 5'd18) ? P[p_addr] : 32'h0;
  function automatic logic [31:0] f_fn(input logic [31:0] a);
    return S[3][a[7:0]] + (S[2][a[15:8]] ^ (S[1][a[23:16]] + S[0][a[31:24]]));
  endfunction
  always @(posedge CLK) s_out <= s_rst_rd ? 32'h0 : s_rd_en ? f_fn(s_addr_rd) : s_out;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic model(input logic [31:0] li, input logic [31:0] ri, output logic [31:0] lo, output logic [31:0] ro);
    logic [31:0] l, r, t;
    l = li ^ P[0];
    r = ri;
    for (int k = 0; k < 16; k++) begin
      exp_addr[k] = l;
      t = l;
      l = r ^ f_fn(l) ^ P[k+1];
      r = t;
    end
    lo = r ^ P[17];
    ro = l;
  endtask
  task automatic run(input logic [31:0] li, input logic [31:0] ri, input int hold, output logic [31:0] lo, output logic [31:0] ro);
    logic [31:0] got_addr [$];
    logic [4:0] got_pa [$];
    logic [31:0] el, er;
    int c, excl, busy;
    model(li, ri, el, er);
    chk("ready_idle", 32'(ready), 1);
    L_in = li; R_in = ri; start = 1;
    step;
    start = 0; L_in = $urandom; R_in = $urandom;
    c = 1; excl = 0; busy = 0;
    while (!valid && c < 100) begin
      if (s_rd_en && s_rst_rd) excl++;
      if (ready) busy++;
      if (s_rd_en) begin
        got_addr.push_back(s_addr_rd);
        got_pa.push_back(p_addr);
      end
      if (c == 34) chk("p_addr_final", 32'(p_addr), 17);
      step;
      c++;
    end
    valid_cyc = cyc;
    chk("latency", 32'(c), 35);
    chk("rd_rst_excl", 32'(excl), 0);
    chk("ready_busy", 32'(busy), 0);
    chk("rd_count", 32'(got_addr.size()), 16);
    for (int k = 0; k < 16 && k < got_addr.size(); k++) begin
      chk("s_addr_rd", got_addr[k], exp_addr[k]);
      chk("p_addr_rd", 32'(got_pa[k]), 32'(k + 1));
    end
    chk("model_L", L_out, el);
    chk("model_R", R_out, er);
    lo = L_out; ro = R_out;
    for (int k = 0; k < hold; k++) begin
      start = 1'($urandom_range(0, 1));
      step;
      chk("hold_L", L_out, el);
      chk("hold_R", R_out, er);
      chk("hold_valid", 32'(valid), 1);
      chk("hold_ready", 32'(ready), 0);
    end
    start = 0; ack = 1;
    step;
    ack = 0;
    chk("valid_after_ack", 32'(valid), 0);
    chk("ready_after_ack", 32'(ready), 1);
  endtask
  typedef struct {logic [31:0] p0, p17, l, r, el, er;} vec_t;
  vec_t tv [6];
  initial begin
    logic [31:0] lo, ro;
    int unsigned t0, t1;
    int bad;
    tv[0] = '{32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h12345678};
    tv[1] = '{32'hFFFFFFFF, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'hEDCBA987};
    tv[2] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    tv[3] = '{32'h0F0F0F0F, 32'h0, 32'hA5A5A5A5, 32'h3C3C3C3C, 32'h3C3C3C3C, 32'hAAAAAAAA};
    tv[4] = '{32'h0, 32'h11111111, 32'h0, 32'h0, 32'h11111111, 32'h0};
    tv[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 18; i++) P[i] = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 256; j++) S[i][j] = 0;
    repeat (3) step;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_L_out", L_out, 0);
    chk("rst_R_out", R_out, 0);
    chk("rst_p_addr", 32'(p_addr), 0);
    chk("rst_s_rd_en", 32'(s_rd_en), 0);
    chk("rst_s_rst_rd", 32'(s_rst_rd), 1);
    rst = 0;
    step;
    chk("ready_after_rst", 32'(ready), 1);
    ack = 1;
    step;
    ack = 0;
    chk("idle_ack_valid", 32'(valid), 0);
    chk("idle_ack_ready", 32'(ready), 1);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 18; k++) P[k] = 0;
      P[0] = tv[i].p0;
      P[17] = tv[i].p17;
      run(tv[i].l, tv[i].r, 0, lo, ro);
      chk("tv_L_out", lo, tv[i].el);
      chk("tv_R_out", ro, tv[i].er);
    end
    for (int i = 0; i < 18; i++) P[i] = $urandom;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 256; j++) S[i][j] = $urandom;
    run(32'h0, 32'h0, 0, lo, ro);
    for (int i = 0; i < 4; i++) run($urandom, $urandom, $urandom_range(0, 3), lo, ro);
    run($urandom, $urandom, 10, lo, ro);
    L_in = $urandom; R_in = $urandom; start = 1;
    step;
    start = 0;
    bad = 0;
    repeat (19) begin
      if (valid) bad++;
      step;
    end
    rst = 1;
    step;
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_valid", 32'(valid), 0);
    rst = 0;
    step;
    chk("midrst_ready_release", 32'(ready), 1);
    repeat (40) begin
      if (valid) bad++;
      step;
    end
    chk("midrst_valid_never", 32'(bad), 0);
    run($urandom, $urandom, 0, lo, ro);
    t0 = valid_cyc;
    run($urandom, $urandom, 0, lo, ro);
    t1 = valid_cyc;
    chk("b2b_spacing_1", t1 - t0, 36);
    run($urandom, $urandom, 0, lo, ro);
    chk("b2b_spacing_2", valid_cyc - t1, 36);
`ifdef BF_ENC_COUNT_EN
    chk("enc_count", enc_count, 3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end
endmodule
